// File: rtl/srv1_bpu_pkg.sv
// Shared types for the branch prediction unit: the per-branch record kept
// between fetch and execute, plus default sizing.
package srv1_bpu_pkg;

    localparam int BRQ_XLEN          = 32;
    localparam int BRQ_DEPTH_DEFAULT = 4;

    typedef struct packed {
        logic                pred;
        logic [BRQ_XLEN-1:0] target;
        logic [BRQ_XLEN-1:0] fallthru;
    } brq_entry_t;

endpackage

// File: rtl/branch_resolve_queue.sv
// In-order queue of predicted branches. Resolves the oldest entry against the
// actual outcome, feeds the predictor and redirects fetch on a mispredict.
module branch_resolve_queue
    import srv1_bpu_pkg::*;
#(
    parameter int DEPTH = BRQ_DEPTH_DEFAULT,
    parameter int XLEN  = BRQ_XLEN
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            clk_en,
    input  logic            flush,
    input  logic            push,
    input  logic            push_pred,
    input  logic [XLEN-1:0] push_target,
    input  logic [XLEN-1:0] push_fallthru,
    output logic            full,
    output logic            empty,
    input  logic            resolve_valid,
    input  logic            resolve_taken,
    input  logic [XLEN-1:0] resolve_target,
    output logic            actual_result,
    output logic            feedback_enable,
    output logic            mispredict,
    output logic [XLEN-1:0] redirect_pc,
    output logic            overflow_err
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    brq_entry_t      mem_q [DEPTH];
    brq_entry_t      mem_d [DEPTH];
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic            fb_q, fb_d;
    logic            act_q, act_d;
    logic            misp_q, misp_d;
    logic            ovf_q, ovf_d;
    logic [XLEN-1:0] redir_q, redir_d;

    brq_entry_t head;
    logic       miss;
    logic       do_resolve;
    logic       pop;
    logic       push_ok;

    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);
    assign head  = mem_q[rd_ptr_q];

    // A taken branch with the right direction still misses if the target differs.
    always_comb begin
        miss = (resolve_taken != head.pred) ||
               (resolve_taken && (resolve_target != head.target));
    end

    always_comb begin
        mem_d      = mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        fb_d       = 1'b0;
        misp_d     = 1'b0;
        act_d      = act_q;
        redir_d    = redir_q;
        ovf_d      = ovf_q;
        do_resolve = resolve_valid && !empty;
        pop        = 1'b0;
        push_ok    = 1'b0;
        if (clk_en) begin
            if ((push && full && !do_resolve) || (resolve_valid && empty)) begin
                ovf_d = 1'b1;
            end
            if (flush) begin
                count_d  = '0;
                rd_ptr_d = wr_ptr_q;
            end else if (do_resolve && miss) begin
                // Everything behind the oldest entry is on the wrong path.
                fb_d     = 1'b1;
                act_d    = resolve_taken;
                misp_d   = 1'b1;
                redir_d  = resolve_taken ? resolve_target : head.fallthru;
                count_d  = '0;
                rd_ptr_d = wr_ptr_q;
            end else begin
                pop     = do_resolve;
                push_ok = push && (!full || pop);
                if (pop) begin
                    fb_d     = 1'b1;
                    act_d    = resolve_taken;
                    rd_ptr_d = rd_ptr_q + 1'b1;
                end
                if (push_ok) begin
                    mem_d[wr_ptr_q] = '{pred: push_pred, target: push_target, fallthru: push_fallthru};
                    wr_ptr_d        = wr_ptr_q + 1'b1;
                end
                count_d = count_q + CW'(push_ok) - CW'(pop);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            fb_q     <= 1'b0;
            act_q    <= 1'b0;
            misp_q   <= 1'b0;
            redir_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            fb_q     <= fb_d;
            act_q    <= act_d;
            misp_q   <= misp_d;
            redir_q  <= redir_d;
            ovf_q    <= ovf_d;
        end
    end

    assign actual_result   = act_q;
    assign feedback_enable = fb_q;
    assign mispredict      = misp_q;
    assign redirect_pc     = redir_q;
    assign overflow_err    = ovf_q;

endmodule

// File: tb/tb_branch_resolve_queue.sv
// Directed vector bench for branch_resolve_queue (DEPTH=4, XLEN=32).
module tb_branch_resolve_queue;

    logic        clk = 1'b0;
    logic        rst;
    logic        clk_en;
    logic        flush;
    logic        push;
    logic        push_pred;
    logic [31:0] push_target;
    logic [31:0] push_fallthru;
    logic        full;
    logic        empty;
    logic        resolve_valid;
    logic        resolve_taken;
    logic [31:0] resolve_target;
    logic        actual_result;
    logic        feedback_enable;
    logic        mispredict;
    logic [31:0] redirect_pc;
    logic        overflow_err;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    branch_resolve_queue dut (
        .clk             (clk),
        .rst             (rst),
        .clk_en          (clk_en),
        .flush           (flush),
        .push            (push),
        .push_pred       (push_pred),
        .push_target     (push_target),
        .push_fallthru   (push_fallthru),
        .full            (full),
        .empty           (empty),
        .resolve_valid   (resolve_valid),
        .resolve_taken   (resolve_taken),
        .resolve_target  (resolve_target),
        .actual_result   (actual_result),
        .feedback_enable (feedback_enable),
        .mispredict      (mispredict),
        .redirect_pc     (redirect_pc),
        .overflow_err    (overflow_err)
    );

    typedef struct {
        logic        ce, fl, pu, pp;
        logic [31:0] pt, pf;
        logic        rv, rt;
        logic [31:0] rtg;
        logic        e_empty, e_full, e_fb, e_act, e_misp;
        logic [31:0] e_redir;
        logic        e_ovf;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic ce, logic fl, logic pu, logic pp, logic [31:0] pt, logic [31:0] pf,
                                logic rv, logic rt, logic [31:0] rtg,
                                logic e_empty, logic e_full, logic e_fb, logic e_act, logic e_misp,
                                logic [31:0] e_redir, logic e_ovf);
        vec_t v;
        v.ce = ce; v.fl = fl; v.pu = pu; v.pp = pp; v.pt = pt; v.pf = pf;
        v.rv = rv; v.rt = rt; v.rtg = rtg;
        v.e_empty = e_empty; v.e_full = e_full; v.e_fb = e_fb; v.e_act = e_act;
        v.e_misp = e_misp; v.e_redir = e_redir; v.e_ovf = e_ovf;
        return v;
    endfunction

    function automatic logic [37:0] outs();
        return {empty, full, feedback_enable, actual_result, mispredict, redirect_pc, overflow_err};
    endfunction

    task automatic check(input string name, input logic [37:0] act, input logic [37:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got {empty,full,fb,act,misp,redir,ovf}=%h expected %h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        clk_en = 1'b1; flush = 1'b0; push = 1'b0; push_pred = 1'b0;
        push_target = '0; push_fallthru = '0;
        resolve_valid = 1'b0; resolve_taken = 1'b0; resolve_target = '0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_push(input logic pp, input logic [31:0] pt, input logic [31:0] pf);
        idle_inputs();
        push = 1'b1; push_pred = pp; push_target = pt; push_fallthru = pf;
        step();
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        rst = 1'b1;
        #12;
        check("reset_state", outs(), {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0});
        @(negedge clk);
        rst = 1'b0;
        #2;

        // ce fl pu pp pt pf | rv rt rtg | empty full fb act misp redir ovf
        tbl.push_back(mk(1,0,1,0,32'h108,32'h104, 0,0,32'h0,   0,0,0,0,0,32'h0,0));
        tbl.push_back(mk(1,0,0,0,32'h0,32'h0,     1,0,32'h0,   1,0,1,0,0,32'h0,0));
        tbl.push_back(mk(1,0,1,0,32'h208,32'h204, 0,0,32'h0,   0,0,0,0,0,32'h0,0));
        tbl.push_back(mk(1,0,0,0,32'h0,32'h0,     1,1,32'h400, 1,0,1,1,1,32'h400,0));
        tbl.push_back(mk(1,0,1,1,32'h300,32'h304, 0,0,32'h0,   0,0,0,1,0,32'h400,0));
        tbl.push_back(mk(1,0,0,0,32'h0,32'h0,     1,1,32'h308, 1,0,1,1,1,32'h308,0));
        tbl.push_back(mk(1,0,1,1,32'h500,32'h504, 0,0,32'h0,   0,0,0,1,0,32'h308,0));
        tbl.push_back(mk(1,0,0,0,32'h0,32'h0,     1,1,32'h500, 1,0,1,1,0,32'h308,0));
        tbl.push_back(mk(1,0,1,1,32'h600,32'h604, 0,0,32'h0,   0,0,0,1,0,32'h308,0));
        tbl.push_back(mk(1,0,0,0,32'h0,32'h0,     1,0,32'h0,   1,0,1,0,1,32'h604,0));
        // stall holds the queue and the pulses
        tbl.push_back(mk(0,0,1,0,32'h708,32'h704, 0,0,32'h0,   1,0,0,0,0,32'h604,0));
        tbl.push_back(mk(1,0,1,0,32'h708,32'h704, 0,0,32'h0,   0,0,0,0,0,32'h604,0));
        tbl.push_back(mk(0,0,0,0,32'h0,32'h0,     1,0,32'h0,   0,0,0,0,0,32'h604,0));
        tbl.push_back(mk(1,0,0,0,32'h0,32'h0,     1,0,32'h0,   1,0,1,0,0,32'h604,0));
        // fill with pointer wrap, then push+pop while full
        tbl.push_back(mk(1,0,1,0,32'h1008,32'h1004, 0,0,32'h0, 0,0,0,0,0,32'h604,0));
        tbl.push_back(mk(1,0,1,1,32'h2000,32'h2004, 0,0,32'h0, 0,0,0,0,0,32'h604,0));
        tbl.push_back(mk(1,0,1,0,32'h3008,32'h3004, 0,0,32'h0, 0,0,0,0,0,32'h604,0));
        tbl.push_back(mk(1,0,1,1,32'h4000,32'h4004, 0,0,32'h0, 0,1,0,0,0,32'h604,0));
        tbl.push_back(mk(1,0,1,0,32'h5008,32'h5004, 1,0,32'h0, 0,1,1,0,0,32'h604,0));
        tbl.push_back(mk(1,0,0,0,32'h0,32'h0,     1,1,32'h2000, 0,0,1,1,0,32'h604,0));
        tbl.push_back(mk(1,0,0,0,32'h0,32'h0,     1,0,32'h0,    0,0,1,0,0,32'h604,0));
        tbl.push_back(mk(1,0,0,0,32'h0,32'h0,     1,1,32'h4000, 0,0,1,1,0,32'h604,0));
        tbl.push_back(mk(1,0,0,0,32'h0,32'h0,     1,0,32'h0,    1,0,1,0,0,32'h604,0));
        // overflow: the fifth push is dropped
        tbl.push_back(mk(1,0,1,0,32'h6008,32'h6004, 0,0,32'h0, 0,0,0,0,0,32'h604,0));
        tbl.push_back(mk(1,0,1,0,32'h6108,32'h6104, 0,0,32'h0, 0,0,0,0,0,32'h604,0));
        tbl.push_back(mk(1,0,1,0,32'h6208,32'h6204, 0,0,32'h0, 0,0,0,0,0,32'h604,0));
        tbl.push_back(mk(1,0,1,0,32'h6308,32'h6304, 0,0,32'h0, 0,1,0,0,0,32'h604,0));
        tbl.push_back(mk(1,0,1,1,32'h9000,32'h9004, 0,0,32'h0, 0,1,0,0,0,32'h604,1));
        tbl.push_back(mk(1,0,0,0,32'h0,32'h0,     1,0,32'h0,   0,0,1,0,0,32'h604,1));
        tbl.push_back(mk(1,0,0,0,32'h0,32'h0,     1,0,32'h0,   0,0,1,0,0,32'h604,1));
        tbl.push_back(mk(1,0,0,0,32'h0,32'h0,     1,0,32'h0,   0,0,1,0,0,32'h604,1));
        tbl.push_back(mk(1,0,0,0,32'h0,32'h0,     1,0,32'h0,   1,0,1,0,0,32'h604,1));
        // mispredict on oldest of three with a same-cycle push
        tbl.push_back(mk(1,0,1,0,32'h7008,32'h7004, 0,0,32'h0, 0,0,0,0,0,32'h604,1));
        tbl.push_back(mk(1,0,1,1,32'h7100,32'h7104, 0,0,32'h0, 0,0,0,0,0,32'h604,1));
        tbl.push_back(mk(1,0,1,0,32'h7208,32'h7204, 0,0,32'h0, 0,0,0,0,0,32'h604,1));
        tbl.push_back(mk(1,0,1,1,32'h8000,32'h8004, 1,1,32'h7777, 1,0,1,1,1,32'h7777,1));
        tbl.push_back(mk(1,0,0,0,32'h0,32'h0,     0,0,32'h0,   1,0,0,1,0,32'h7777,1));
        // flush beats a same-cycle resolve
        tbl.push_back(mk(1,0,1,0,32'h7308,32'h7304, 0,0,32'h0, 0,0,0,1,0,32'h7777,1));
        tbl.push_back(mk(1,1,0,0,32'h0,32'h0,     1,1,32'h7300, 1,0,0,1,0,32'h7777,1));
        tbl.push_back(mk(1,0,1,0,32'h7408,32'h7404, 0,0,32'h0, 0,0,0,1,0,32'h7777,1));
        tbl.push_back(mk(1,0,0,0,32'h0,32'h0,     1,0,32'h0,   1,0,1,0,0,32'h7777,1));

        foreach (tbl[i]) begin
            clk_en = tbl[i].ce; flush = tbl[i].fl; push = tbl[i].pu; push_pred = tbl[i].pp;
            push_target = tbl[i].pt; push_fallthru = tbl[i].pf;
            resolve_valid = tbl[i].rv; resolve_taken = tbl[i].rt; resolve_target = tbl[i].rtg;
            step();
            check($sformatf("row%0d", i), outs(),
                  {tbl[i].e_empty, tbl[i].e_full, tbl[i].e_fb, tbl[i].e_act, tbl[i].e_misp,
                   tbl[i].e_redir, tbl[i].e_ovf});
        end
        idle_inputs();

        // Asynchronous reset mid-run with three entries queued
        do_push(1'b0, 32'ha008, 32'ha004);
        do_push(1'b1, 32'hb000, 32'hb004);
        resolve_valid = 1'b1; resolve_taken = 1'b1; resolve_target = 32'hbeef;
        push = 1'b1; push_pred = 1'b0; push_fallthru = 32'hc004;
        step();
        idle_inputs();
        check("pre_rst_miss", outs(), {1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 32'hbeef, 1'b1});
        do_push(1'b0, 32'hd008, 32'hd004);
        do_push(1'b0, 32'hd108, 32'hd104);
        do_push(1'b0, 32'hd208, 32'hd204);
        #2 rst = 1'b1;
        #1 check("async_rst", outs(), {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0});
        #2 rst = 1'b0;
        step();
        check("post_rst", outs(), {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0});
        do_push(1'b0, 32'h108, 32'h104);
        resolve_valid = 1'b1; resolve_taken = 1'b0;
        step();
        idle_inputs();
        check("post_rst_hit", outs(), {1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0});

        // Resolve with nothing queued
        resolve_valid = 1'b1; resolve_taken = 1'b1; resolve_target = 32'h444;
        step();
        idle_inputs();
        check("resolve_empty", outs(), {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1});
        step();
        check("ovf_sticky", outs(), {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1});

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
